// File: rtl/sa_autosa_cacc_pkg.sv
// Shared definitions for the CACC accumulation sequencer.
//   CACC_IN_W / CACC_PSUM_W : MAC result and partial-sum widths
//   CALC_LAT                : calc in_* -> out_partial_* latency in cycles
//   cacc_state_e            : sequencer FSM states
//   inflight_t              : one in-flight write-back slot {valid, addr}
package sa_autosa_cacc_pkg;

    localparam int CACC_IN_W       = 22;
    localparam int CACC_PSUM_W     = 34;
    localparam int CALC_LAT        = 2;
    // One registered output stage in front of the calc, then CALC_LAT cycles.
    localparam int INFLIGHT_STAGES = CALC_LAT + 1;
    // Address field width of the in-flight slot; the top requires ADDR_W <= this.
    localparam int ADDR_MAX_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } cacc_state_e;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_MAX_W-1:0] addr;
    } inflight_t;

endpackage

// File: rtl/sa_autosa_cacc_psum_rf.sv
// Partial-sum register file: DEPTH x DATA_W, one combinational read port and
// one synchronous write port. Contents are deliberately not reset.
//   autosa_core_clk : clock
//   wr_en/wr_addr/wr_data : write port, takes effect at the rising edge
//   rd_addr/rd_data       : asynchronous read port
module sa_autosa_cacc_psum_rf
    import sa_autosa_cacc_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = CACC_PSUM_W
) (
    input  logic              autosa_core_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge autosa_core_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sa_autosa_cacc_assembly_ctrl.sv
// Accumulation sequencer for one CACC lane. Accepts MAC results, reads the
// stored partial sum for the current entry, drives the calc inputs one cycle
// later, and writes the calc's partial result back CALC_LAT cycles after that.
// Stalls the MAC stream while an in-flight write-back targets the entry about
// to be read.
//   cfg_stripe_len/cfg_grp_num/op_en : job config (minus-1 encoded) and start
//   mac_valid/mac_data/mac_ready     : MAC result stream
//   calc_in_*                        : registered drive to the calc
//   calc_out_partial_*               : calc result, written back to the buffer
//   busy/done/wb_err                 : status; wb_err is sticky until op_en
module sa_autosa_cacc_assembly_ctrl
    import sa_autosa_cacc_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int GRP_W  = 8
) (
    input  logic                   autosa_core_clk,
    input  logic                   autosa_core_rstn,
    input  logic [ADDR_W-1:0]      cfg_stripe_len,
    input  logic [GRP_W-1:0]       cfg_grp_num,
    input  logic                   op_en,
    input  logic                   mac_valid,
    input  logic [CACC_IN_W-1:0]   mac_data,
    output logic                   mac_ready,
    output logic [CACC_IN_W-1:0]   calc_in_data,
    output logic [CACC_PSUM_W-1:0] calc_in_op,
    output logic                   calc_in_op_valid,
    output logic                   calc_in_sel,
    output logic                   calc_in_valid,
    input  logic [CACC_PSUM_W-1:0] calc_out_partial_data,
    input  logic                   calc_out_partial_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   wb_err
);

    cacc_state_e state, state_nxt;

    logic [ADDR_W-1:0] stripe_len_q;
    logic [GRP_W-1:0]  grp_num_q;
    logic [ADDR_W-1:0] e;
    logic [GRP_W-1:0]  g;

    // inflight[] carries write-back intent (final-group beats are marked
    // invalid); vld_pipe tracks occupancy of every beat, so DRAIN also waits
    // for final-group beats that never write back.
    inflight_t [INFLIGHT_STAGES-1:0] inflight;
    logic      [INFLIGHT_STAGES-1:0] vld_pipe;
    inflight_t                       push;
    inflight_t                       wb_stage;

    logic                   start;
    logic                   accept;
    logic                   hazard;
    logic                   last_ent;
    logic                   last_grp;
    logic                   pipe_empty;
    logic                   wb_en;
    logic [CACC_PSUM_W-1:0] rd_data;

    assign start      = (state == ST_IDLE) && op_en;
    assign accept     = mac_valid && mac_ready;
    assign last_ent   = (e == stripe_len_q);
    assign last_grp   = (g == grp_num_q);
    assign pipe_empty = ~|vld_pipe;
    assign wb_stage   = inflight[INFLIGHT_STAGES-1];
    assign wb_en      = calc_out_partial_valid && wb_stage.valid;

    // Any pending write-back to the entry we would read next blocks the read;
    // the buffer only holds the fresh value from the cycle after stage 3.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < INFLIGHT_STAGES; i++) begin
            if (inflight[i].valid && (inflight[i].addr == ADDR_MAX_W'(e))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        push = '0;
        if (accept) begin
            push.valid = ~last_grp;
            push.addr  = ADDR_MAX_W'(e);
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mac_ready = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy      = 1'b1;
                mac_ready = ~hazard;
                if (accept && last_ent && last_grp) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (pipe_empty) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------- config/counters
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            stripe_len_q <= '0;
            grp_num_q    <= '0;
            e            <= '0;
            g            <= '0;
        end else if (start) begin
            stripe_len_q <= cfg_stripe_len;
            grp_num_q    <= cfg_grp_num;
            e            <= '0;
            g            <= '0;
        end else if (accept) begin
            if (last_ent) begin
                e <= '0;
                g <= g + 1'b1;
            end else begin
                e <= e + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------- calc drive
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            calc_in_valid    <= 1'b0;
            calc_in_data     <= '0;
            calc_in_op       <= '0;
            calc_in_op_valid <= 1'b0;
            calc_in_sel      <= 1'b0;
        end else begin
            calc_in_valid <= accept;
            if (accept) begin
                calc_in_data     <= mac_data;
                calc_in_op       <= rd_data;
                // Group 0 starts a fresh sum; the calc ignores in_op then.
                calc_in_op_valid <= (g != '0);
                calc_in_sel      <= last_grp;
            end
        end
    end

    // ------------------------------------------------- in-flight tracking
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            inflight <= '0;
            vld_pipe <= '0;
        end else begin
            inflight <= {inflight[INFLIGHT_STAGES-2:0], push};
            vld_pipe <= {vld_pipe[INFLIGHT_STAGES-2:0], accept};
        end
    end

    // Stale calc results after a reset land while IDLE and are not flagged.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            wb_err <= 1'b0;
        end else if (start) begin
            wb_err <= 1'b0;
        end else if ((state != ST_IDLE) && (calc_out_partial_valid != wb_stage.valid)) begin
            wb_err <= 1'b1;
        end
    end

    sa_autosa_cacc_psum_rf #(
        .ADDR_W (ADDR_W),
        .DATA_W (CACC_PSUM_W)
    ) u_psum_rf (
        .autosa_core_clk (autosa_core_clk),
        .wr_en           (wb_en),
        .wr_addr         (wb_stage.addr[ADDR_W-1:0]),
        .wr_data         (calc_out_partial_data),
        .rd_addr         (e),
        .rd_data         (rd_data)
    );

endmodule

// File: tb/tb_sa_autosa_cacc_assembly_ctrl.sv
// Self-checking bench: randomized MAC streams with a calc model attached,
// compared against an accumulate-per-entry reference model.
module tb_sa_autosa_cacc_assembly_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [5:0]  cfg_stripe_len = '0;
    logic [7:0]  cfg_grp_num = '0;
    logic        op_en = 1'b0;
    logic        mac_valid = 1'b0;
    logic [21:0] mac_data = '0;
    logic        mac_ready;
    logic [21:0] calc_in_data;
    logic [33:0] calc_in_op;
    logic        calc_in_op_valid, calc_in_sel, calc_in_valid;
    logic [33:0] calc_out_partial_data;
    logic        calc_out_partial_valid;
    logic        busy, done, wb_err;
    logic        inj = 1'b0;

    always #5 clk = ~clk;

    sa_autosa_cacc_assembly_ctrl #(.ADDR_W(6), .GRP_W(8)) dut (
        .autosa_core_clk        (clk),
        .autosa_core_rstn       (rstn),
        .cfg_stripe_len         (cfg_stripe_len),
        .cfg_grp_num            (cfg_grp_num),
        .op_en                  (op_en),
        .mac_valid              (mac_valid),
        .mac_data               (mac_data),
        .mac_ready              (mac_ready),
        .calc_in_data           (calc_in_data),
        .calc_in_op             (calc_in_op),
        .calc_in_op_valid       (calc_in_op_valid),
        .calc_in_sel            (calc_in_sel),
        .calc_in_valid          (calc_in_valid),
        .calc_out_partial_data  (calc_out_partial_data),
        .calc_out_partial_valid (calc_out_partial_valid),
        .busy                   (busy),
        .done                   (done),
        .wb_err                 (wb_err)
    );

    // Calc model: two-cycle latency, partial result only for non-final beats.
    logic        a_v = 1'b0, b_v = 1'b0;
    logic [33:0] a_d = '0, b_d = '0;
    always @(posedge clk) begin
        a_v <= calc_in_valid & ~calc_in_sel;
        a_d <= {{12{calc_in_data[21]}}, calc_in_data} + (calc_in_op_valid ? calc_in_op : 34'd0);
        b_v <= a_v;
        b_d <= a_d;
    end
    assign calc_out_partial_valid = b_v | inj;
    assign calc_out_partial_data  = b_d;

    typedef struct {
        logic [21:0] d;
        logic [33:0] op;
        logic        opv;
        logic        sel;
    } rec_t;

    rec_t        obs_q[$];
    rec_t        exp_q[$];
    rec_t        mon_r;
    logic [21:0] beats[$];
    longint      acc_t[$];
    longint      done_q[$];
    int          stall_cnt;
    bit          aborted;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        if (rstn && calc_in_valid) begin
            mon_r.d   = calc_in_data;
            mon_r.op  = calc_in_op;
            mon_r.opv = calc_in_op_valid;
            mon_r.sel = calc_in_sel;
            obs_q.push_back(mon_r);
        end
        if (done) done_q.push_back(longint'($time));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    // Reference: each entry accumulates sign-extended data across groups;
    // group g>0 sees the sum of groups 0..g-1 at that entry.
    task automatic build_expected(input int len, input int grp);
        logic [33:0] ps [0:63];
        rec_t r;
        exp_q.delete();
        for (int i = 0; i < beats.size(); i++) begin
            int gi;
            int ei;
            gi = i / (len + 1);
            ei = i % (len + 1);
            r.d   = beats[i];
            r.opv = (gi != 0);
            r.op  = (gi == 0) ? 34'd0 : ps[ei];
            r.sel = (gi == grp);
            ps[ei] = r.op + {{12{beats[i][21]}}, beats[i]};
            exp_q.push_back(r);
        end
    endtask

    // mode: 0 random, 1 data i+1, 2 group0=5 else 7, 3 first beat -3 then random
    task automatic run_job(input int len, input int grp, input int mode, input int gap_pct,
                           input int abort_at, input int open_at, input int inj_at);
        int nb, idx, guard;
        bit rdy, opened, injd;
        nb = (len + 1) * (grp + 1);
        beats.delete();
        for (int i = 0; i < nb; i++) begin
            case (mode)
                1: beats.push_back(22'(i + 1));
                2: beats.push_back((i / (len + 1) == 0) ? 22'd5 : 22'd7);
                3: beats.push_back((i == 0) ? 22'h3FFFFD : 22'($urandom()));
                default: beats.push_back(22'($urandom()));
            endcase
        end
        obs_q.delete(); acc_t.delete(); done_q.delete();
        stall_cnt = 0; aborted = 0; opened = 0; injd = 0;
        @(negedge clk);
        cfg_stripe_len = 6'(len); cfg_grp_num = 8'(grp); op_en = 1'b1;
        @(negedge clk);
        op_en = 1'b0;
        idx = 0; guard = 0;
        while (idx < nb && guard < 4000) begin
            guard++;
            if (int'($urandom_range(99)) < gap_pct) begin
                mac_valid = 1'b0; mac_data = '0;
            end else begin
                mac_valid = 1'b1; mac_data = beats[idx];
            end
            op_en = 1'b0; inj = 1'b0;
            cfg_stripe_len = 6'(len); cfg_grp_num = 8'(grp);
            if (open_at == idx && !opened) begin
                op_en = 1'b1; cfg_stripe_len = 6'(len + 2); cfg_grp_num = 8'(grp + 3); opened = 1;
            end
            if (inj_at == idx && !injd) begin
                inj = 1'b1; injd = 1;
            end
            #1 rdy = mac_ready;
            if (mac_valid && !rdy) stall_cnt++;
            @(posedge clk);
            if (mac_valid && rdy) begin
                acc_t.push_back(longint'($time));
                idx++;
            end
            @(negedge clk);
            if (abort_at > 0 && idx == abort_at) begin
                aborted = 1;
                break;
            end
        end
        mac_valid = 1'b0; op_en = 1'b0; inj = 1'b0;
        cfg_stripe_len = 6'(len); cfg_grp_num = 8'(grp);
        if (!aborted) begin
            n_checks++;
            if (idx != nb) begin
                n_fail++;
                $display("FAIL job_accept_timeout: accepted %0d beats, want %0d", idx, nb);
            end
            for (int k = 0; k < 40 && done_q.size() == 0; k++) begin
                @(negedge clk); #1;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mac_ready, busy, done, calc_in_valid, wb_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/busy/done/vld/err=%b want 00000",
                     {mac_ready, busy, done, calc_in_valid, wb_err});
        end
        n_checks++;
        if (calc_in_data !== 22'd0 || calc_in_op !== 34'd0 || calc_in_sel !== 1'b0 || calc_in_op_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_calc: got d=%h op=%h sel=%b opv=%b want all 0",
                     calc_in_data, calc_in_op, calc_in_sel, calc_in_op_valid);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mac_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b rdy=%b want 0 0", busy, mac_ready);
        end
    endtask

    task automatic test_single_group();
        run_job(3, 0, 1, 0, 0, -1, -1);
        n_checks++;
        if (obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL single_count: got %0d beats want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].d !== 22'(i + 1) || obs_q[i].sel !== 1'b1 || obs_q[i].opv !== 1'b0) begin
                n_fail++;
                $display("FAIL single_beat%0d: got d=%0d sel=%b opv=%b want d=%0d sel=1 opv=0",
                         i, obs_q[i].d, obs_q[i].sel, obs_q[i].opv, i + 1);
            end
        end
        n_checks++;
        if (done_q.size() != 1 || acc_t.size() == 0 ||
            (done_q[0] + 5 - acc_t[acc_t.size()-1]) / 10 != 4) begin
            n_fail++;
            $display("FAIL single_done_latency: got %0d done pulses, latency %0d want 1 pulse latency 4",
                     done_q.size(), (done_q.size() > 0 && acc_t.size() > 0) ?
                     (done_q[0] + 5 - acc_t[acc_t.size()-1]) / 10 : -1);
        end
        n_checks++;
        if (busy !== 1'b0 || wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got busy=%b err=%b want 0 0", busy, wb_err);
        end
    endtask

    task automatic test_two_groups();
        run_job(3, 1, 2, 0, 0, -1, -1);
        n_checks++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL two_count: got %0d beats want 8", obs_q.size());
        end
        for (int i = 4; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].op !== 34'd5 || obs_q[i].opv !== 1'b1 || obs_q[i].sel !== 1'b1 || obs_q[i].d !== 22'd7) begin
                n_fail++;
                $display("FAIL two_grp1_beat%0d: got op=%0d opv=%b sel=%b d=%0d want 5 1 1 7",
                         i, obs_q[i].op, obs_q[i].opv, obs_q[i].sel, obs_q[i].d);
            end
        end
        n_checks++;
        if (wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL two_wb_err: got %b want 0", wb_err);
        end
    endtask

    task automatic test_negative();
        run_job(3, 1, 3, 10, 0, -1, -1);
        n_checks++;
        if (obs_q.size() != 8 || obs_q[4].op !== 34'h3_FFFF_FFFD || obs_q[4].opv !== 1'b1) begin
            n_fail++;
            $display("FAIL negative_op: got op=%h opv=%b want 3fffffffd 1",
                     (obs_q.size() > 4) ? obs_q[4].op : 34'd0, (obs_q.size() > 4) ? obs_q[4].opv : 1'b0);
        end
    endtask

    task automatic test_hazard();
        logic [33:0] v0, v1;
        run_job(0, 2, 0, 0, 0, -1, -1);
        v0 = {{12{beats[0][21]}}, beats[0]};
        v1 = {{12{beats[1][21]}}, beats[1]};
        n_checks++;
        if (stall_cnt != 6) begin
            n_fail++;
            $display("FAIL hazard_stalls: got %0d stall cycles want 6", stall_cnt);
        end
        n_checks++;
        if (acc_t.size() != 3 || acc_t[1] - acc_t[0] != 40 || acc_t[2] - acc_t[1] != 40) begin
            n_fail++;
            $display("FAIL hazard_spacing: got %0d accepts want 3 spaced by 4 cycles", acc_t.size());
        end
        n_checks++;
        if (obs_q.size() != 3 || obs_q[0].opv !== 1'b0 || obs_q[1].op !== v0 || obs_q[2].op !== v0 + v1 ||
            obs_q[2].sel !== 1'b1 || obs_q[1].sel !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_ops: got %0d beats op1=%h op2=%h want op1=%h op2=%h",
                     obs_q.size(), (obs_q.size() > 1) ? obs_q[1].op : 34'd0,
                     (obs_q.size() > 2) ? obs_q[2].op : 34'd0, v0, v0 + v1);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int len, grp;
            len = int'($urandom_range(7));
            grp = int'($urandom_range(3));
            run_job(len, grp, 0, 30, 0, -1, -1);
            build_expected(len, grp);
            n_checks++;
            if (obs_q.size() != exp_q.size() || done_q.size() != 1 || wb_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_shape: got beats=%0d done=%0d err=%b want %0d 1 0",
                         t, obs_q.size(), done_q.size(), wb_err, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i].d !== exp_q[i].d || obs_q[i].opv !== exp_q[i].opv || obs_q[i].sel !== exp_q[i].sel ||
                    (exp_q[i].opv && obs_q[i].op !== exp_q[i].op)) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got d=%h op=%h opv=%b sel=%b want d=%h op=%h opv=%b sel=%b",
                             t, i, obs_q[i].d, obs_q[i].op, obs_q[i].opv, obs_q[i].sel,
                             exp_q[i].d, exp_q[i].op, exp_q[i].opv, exp_q[i].sel);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        run_job(3, 2, 0, 0, 6, -1, -1);
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({calc_in_valid, calc_in_sel, calc_in_op_valid, busy, mac_ready, done} !== 6'b0 ||
            calc_in_data !== 22'd0 || calc_in_op !== 34'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got vld/sel/opv/busy/rdy/done=%b d=%h op=%h want all 0",
                     {calc_in_valid, calc_in_sel, calc_in_op_valid, busy, mac_ready, done}, calc_in_data, calc_in_op);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wb_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: got err=%b busy=%b want 0 0", wb_err, busy);
        end
        run_job(3, 1, 0, 20, 0, -1, -1);
        build_expected(3, 1);
        n_checks++;
        if (obs_q.size() != exp_q.size() || done_q.size() != 1 || wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_rerun: got beats=%0d done=%0d err=%b want %0d 1 0",
                     obs_q.size(), done_q.size(), wb_err, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].opv !== exp_q[i].opv || obs_q[i].sel !== exp_q[i].sel ||
                (exp_q[i].opv && obs_q[i].op !== exp_q[i].op)) begin
                n_fail++;
                $display("FAIL midreset_beat%0d: got op=%h opv=%b sel=%b want op=%h opv=%b sel=%b",
                         i, obs_q[i].op, obs_q[i].opv, obs_q[i].sel, exp_q[i].op, exp_q[i].opv, exp_q[i].sel);
            end
        end
    endtask

    task automatic test_op_en_in_run();
        run_job(3, 1, 0, 0, 0, 3, -1);
        build_expected(3, 1);
        n_checks++;
        if (obs_q.size() != 8 || done_q.size() != 1) begin
            n_fail++;
            $display("FAIL open_shape: got beats=%0d done=%0d want 8 1", obs_q.size(), done_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].sel !== exp_q[i].sel || obs_q[i].opv !== exp_q[i].opv ||
                (exp_q[i].opv && obs_q[i].op !== exp_q[i].op)) begin
                n_fail++;
                $display("FAIL open_beat%0d: got op=%h opv=%b sel=%b want op=%h opv=%b sel=%b",
                         i, obs_q[i].op, obs_q[i].opv, obs_q[i].sel, exp_q[i].op, exp_q[i].opv, exp_q[i].sel);
            end
        end
    endtask

    task automatic test_wb_err();
        run_job(3, 0, 0, 0, 0, -1, 0);
        n_checks++;
        if (wb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wberr_set: got %b want 1", wb_err);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (wb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wberr_sticky: got %b want 1", wb_err);
        end
        run_job(0, 0, 0, 0, 0, -1, -1);
        n_checks++;
        if (wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wberr_clear: got %b want 0", wb_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_two_groups();
        test_negative();
        test_hazard();
        test_random();
        test_reset_mid_run();
        test_op_en_in_run();
        test_wb_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
